// File: rtl/vgaconsole_pkg.sv
// Shared definitions for the VGA text console: glyph geometry, fetch FSM states
// and the glyph row extraction helper.
package vgaconsole_pkg;

  localparam int unsigned GLYPH_W    = 5;
  localparam int unsigned GLYPH_H    = 7;
  localparam int unsigned GLYPH_BITS = GLYPH_W * GLYPH_H;
  localparam int unsigned DEF_CELL_W = 6;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StCapture,
    StLookup,
    StWait
  } fetch_state_e;

  // Row r sits at rom[34-5r -: 5] with the leftmost pixel in the MSB; rows past
  // the glyph height are the blank inter-row gap.
  function automatic logic [GLYPH_W-1:0] glyph_row_bits(input logic [GLYPH_BITS-1:0] rom,
                                                        input logic [2:0]            row);
    logic [GLYPH_BITS-1:0] sh;
    sh = rom << (GLYPH_W * row);
    return (row >= 3'(GLYPH_H)) ? '0 : sh[GLYPH_BITS-1 -: GLYPH_W];
  endfunction

endpackage

// File: rtl/cell_shifter.sv
// Current-cell pixel buffer: shifts one pixel per pix_en and reloads from the
// next buffer so that consecutive cells stream without gaps.
module cell_shifter
  import vgaconsole_pkg::*;
#(
  parameter int unsigned CellW = DEF_CELL_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             pix_en_i,
  input  logic             next_valid_i,
  input  logic [CellW-1:0] next_bits_i,
  input  logic             next_last_i,
  output logic             take_o,
  output logic             starved_o,
  output logic             last_out_o,
  output logic             pixel_o
);

  localparam int unsigned CntW = $clog2(CellW + 1);

  logic [CellW-1:0] sr_q;
  logic [CntW-1:0]  cnt_q;
  logic             last_q;

  assign starved_o  = (cnt_q == '0);
  assign take_o     = next_valid_i && !flush_i &&
                      (starved_o || (cnt_q == CntW'(1) && pix_en_i));
  assign last_out_o = !flush_i && pix_en_i && last_q && (cnt_q == CntW'(1));
  // Zeros shift in, so a drained register already reads as a blank pixel.
  assign pixel_o    = sr_q[CellW-1];

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      sr_q   <= '0;
      cnt_q  <= '0;
      last_q <= 1'b0;
    end else if (take_o) begin
      sr_q   <= next_bits_i;
      cnt_q  <= CntW'(CellW);
      last_q <= next_last_i;
    end else if (pix_en_i && !starved_o) begin
      sr_q  <= sr_q << 1;
      cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/glyph_fetch_sequencer.sv
// Scanline glyph sequencer: fetches one text row's characters, slices the
// current glyph row from the character ROM and streams it out per pix_en.
module glyph_fetch_sequencer
  import vgaconsole_pkg::*;
#(
  parameter int unsigned COLS   = 16,
  parameter int unsigned ROWS   = 4,
  parameter int unsigned CELL_W = DEF_CELL_W,
  parameter int unsigned ADDR_W = $clog2(COLS * ROWS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    line_start,
  input  logic [2:0]              glyph_row,
  input  logic [$clog2(ROWS)-1:0] text_row,
  input  logic                    pix_en,
  output logic                    txt_req,
  output logic [ADDR_W-1:0]       txt_addr,
  input  logic                    txt_gnt,
  input  logic [7:0]              txt_data,
  output logic [6:0]              rom_addr,
  input  logic [GLYPH_BITS-1:0]   rom_data,
  output logic                    pixel,
  output logic                    active,
  output logic                    underrun,
  output logic                    line_done
);

  localparam int unsigned COL_W = $clog2(COLS);
  localparam int unsigned ROW_W = $clog2(ROWS);

  fetch_state_e      state_q, state_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q;
  logic [2:0]        grow_q;
  logic [7:0]        code_q;
  logic [CELL_W-1:0] next_bits_q;
  logic              next_valid_q;
  logic              next_last_q;
  logic              txt_req_q;
  logic              active_q;
  logic              underrun_q;
  logic              line_done_q;
  logic [CELL_W-1:0] cell_bits;
  logic              take;
  logic              starved;
  logic              last_out;
  logic              is_last_col;

  assign is_last_col = (col_q == COL_W'(COLS - 1));
  assign txt_addr    = ADDR_W'(row_q * COLS + col_q);
  assign rom_addr    = code_q[6:0];
  assign txt_req     = txt_req_q;
  assign active      = active_q;
  assign underrun    = underrun_q;
  assign line_done   = line_done_q;

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    if (line_start) begin
      state_d = StFetch;
      col_d   = '0;
    end else begin
      case (state_q)
        StIdle:    state_d = StIdle;
        StFetch:   if (txt_gnt) state_d = StCapture;
        StCapture: state_d = StLookup;
        StLookup:  state_d = is_last_col ? StIdle : StWait;
        StWait: begin
          if (!next_valid_q) begin
            col_d   = col_q + 1'b1;
            state_d = StFetch;
          end
        end
        default:   state_d = StIdle;
      endcase
    end
  end

  // Inverse video flips the gap column too, giving solid inverse cells.
  always_comb begin
    cell_bits = '0;
    cell_bits[CELL_W-1 -: GLYPH_W] = glyph_row_bits(rom_data, grow_q);
    cell_bits = cell_bits ^ {CELL_W{code_q[7]}};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      col_q        <= '0;
      row_q        <= '0;
      grow_q       <= '0;
      code_q       <= '0;
      next_bits_q  <= '0;
      next_valid_q <= 1'b0;
      next_last_q  <= 1'b0;
      txt_req_q    <= 1'b0;
      active_q     <= 1'b0;
      underrun_q   <= 1'b0;
      line_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      txt_req_q <= (state_d == StFetch);
      if (line_start) begin
        row_q  <= text_row;
        grow_q <= glyph_row;
      end
      // A grant in flight when a line restarts lands in FETCH and is dropped.
      if (state_q == StCapture && !line_start) code_q <= txt_data;

      if (line_start) begin
        next_valid_q <= 1'b0;
      end else if (state_q == StLookup) begin
        next_bits_q  <= cell_bits;
        next_valid_q <= 1'b1;
        next_last_q  <= is_last_col;
      end else if (take) begin
        next_valid_q <= 1'b0;
      end

      if (line_start || last_out) active_q <= 1'b0;
      else if (take)              active_q <= 1'b1;

      if (line_start)                          underrun_q <= 1'b0;
      else if (pix_en && active_q && starved)  underrun_q <= 1'b1;

      line_done_q <= !line_start && last_out;
    end
  end

  cell_shifter #(
    .CellW(CELL_W)
  ) u_cell_shifter (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (line_start),
    .pix_en_i    (pix_en),
    .next_valid_i(next_valid_q),
    .next_bits_i (next_bits_q),
    .next_last_i (next_last_q),
    .take_o      (take),
    .starved_o   (starved),
    .last_out_o  (last_out),
    .pixel_o     (pixel)
  );

endmodule

// File: tb/tb_glyph_fetch_sequencer.sv
// Directed bench for glyph_fetch_sequencer with a text-buffer responder and a
// small character ROM holding solid blocks, a blank space and the letter A.
module tb_glyph_fetch_sequencer;
  import vgaconsole_pkg::*;

  localparam int unsigned ADDR_W = 6;
  localparam logic [34:0] GLYPH_A = {5'b01110, 5'b10001, 5'b10001, 5'b11111,
                                     5'b10001, 5'b10001, 5'b10001};

  logic              clk = 1'b0;
  logic              rst, line_start, pix_en;
  logic [2:0]        glyph_row;
  logic [1:0]        text_row;
  logic              txt_req, txt_gnt;
  logic [ADDR_W-1:0] txt_addr;
  logic [7:0]        txt_data = 8'h00;
  logic [6:0]        rom_addr;
  logic [34:0]       rom_data;
  logic              pixel, active, underrun, line_done;

  int                n_vec = 0;
  int                n_err = 0;
  logic [7:0]        mem [64];
  logic              stall_on = 1'b0;
  logic [ADDR_W-1:0] stall_addr = '0;
  int                stall_cnt = 0;
  logic [ADDR_W-1:0] addr_log [$];

  always #5 clk = ~clk;

  glyph_fetch_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .line_start(line_start),
    .glyph_row (glyph_row),
    .text_row  (text_row),
    .pix_en    (pix_en),
    .txt_req   (txt_req),
    .txt_addr  (txt_addr),
    .txt_gnt   (txt_gnt),
    .txt_data  (txt_data),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .pixel     (pixel),
    .active    (active),
    .underrun  (underrun),
    .line_done (line_done)
  );

  always_comb begin
    if (rom_addr < 7'd32 || rom_addr == 7'h7F) rom_data = '1;
    else if (rom_addr == 7'h41)                rom_data = GLYPH_A;
    else                                       rom_data = '0;
  end

  // Grant withheld for 10 requesting cycles on the selected address.
  assign txt_gnt = !(stall_on && txt_addr == stall_addr && stall_cnt < 10);

  always @(posedge clk) begin
    if (line_start) begin
      stall_cnt <= 0;
      addr_log.delete();
    end else if (txt_req) begin
      if (txt_gnt) begin
        txt_data <= mem[txt_addr];
        addr_log.push_back(txt_addr);
      end else begin
        stall_cnt <= stall_cnt + 1;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic fill_row(input int r, input logic [7:0] b);
    for (int c = 0; c < 16; c++) mem[r*16+c] = b;
  endtask

  task automatic play_line(input string tag, input logic [1:0] trow, input logic [2:0] grow,
                           input logic [6:0] exp_rom, input logic [127:0] exp_stream,
                           input int exp_done, input logic exp_ur);
    logic [127:0] got;
    int           ndone;
    got   = '0;
    ndone = -1;
    text_row   = trow;
    glyph_row  = grow;
    pix_en     = 1'b0;
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    check_eq({tag, "_req_t1"}, 128'(txt_req), 128'(1'b1));
    check_eq({tag, "_addr_t1"}, 128'(txt_addr), 128'({trow, 4'b0000}));
    check_eq({tag, "_ur_clr_t1"}, 128'(underrun), 128'(1'b0));
    tick();
    tick();
    check_eq({tag, "_rom_t3"}, 128'(rom_addr), 128'(exp_rom));
    tick();
    check_eq({tag, "_act_t4"}, 128'(active), 128'(1'b0));
    check_eq({tag, "_pix_t4"}, 128'(pixel), 128'(1'b0));
    tick();
    pix_en = 1'b1;
    for (int n = 0; n < 200; n++) begin
      if (line_done) begin
        ndone = n;
        break;
      end
      if (active) got = {got[126:0], pixel};
      tick();
    end
    pix_en = 1'b0;
    check_eq({tag, "_done_at"}, 128'(ndone), 128'(exp_done));
    check_eq({tag, "_stream"}, got, exp_stream);
    check_eq({tag, "_act_off"}, 128'(active), 128'(1'b0));
    check_eq({tag, "_underrun"}, 128'(underrun), 128'(exp_ur));
    tick();
    check_eq({tag, "_done_pulse"}, 128'(line_done), 128'(1'b0));
  endtask

  initial begin
    logic [127:0] e;
    rst        = 1'b1;
    line_start = 1'b0;
    pix_en     = 1'b0;
    glyph_row  = 3'd0;
    text_row   = 2'd0;
    for (int i = 0; i < 64; i++) mem[i] = 8'h7F;
    tick();
    tick();
    rst = 1'b0;
    check_eq("rst_req", 128'(txt_req), 128'(1'b0));
    check_eq("rst_pixel", 128'(pixel), 128'(1'b0));
    check_eq("rst_active", 128'(active), 128'(1'b0));
    check_eq("rst_underrun", 128'(underrun), 128'(1'b0));
    check_eq("rst_done", 128'(line_done), 128'(1'b0));
    check_eq("rst_rom", 128'(rom_addr), 128'(7'd0));
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("idle_no_req", 128'(txt_req), 128'(1'b0));
    end

    fill_row(0, 8'h7F);
    play_line("solid", 2'd0, 3'd0, 7'h7F, 128'({16{6'b111110}}), 96, 1'b0);
    fill_row(0, 8'hA0);
    play_line("inv_space", 2'd0, 3'd0, 7'h20, 128'({16{6'b111111}}), 96, 1'b0);
    fill_row(0, 8'hC1);
    play_line("inv_a", 2'd0, 3'd0, 7'h41, 128'({16{6'b100011}}), 96, 1'b0);
    fill_row(0, 8'h7F);
    play_line("gap_row", 2'd0, 3'd7, 7'h7F, 128'(0), 96, 1'b0);
    check_eq("gap_row_fetches", 128'(addr_log.size()), 128'(16));

    // Mixed row 1 with a 10-cycle grant stall on column 1.
    for (int c = 0; c < 16; c++) begin
      case (c % 3)
        0:       mem[16+c] = 8'h41;
        1:       mem[16+c] = 8'h7F;
        default: mem[16+c] = 8'hC1;
      endcase
    end
    e = '0;
    for (int c = 0; c < 16; c++) begin
      case (c % 3)
        0:       e = {e[121:0], 6'b011100};
        1:       e = {e[121:0], 6'b111110};
        default: e = {e[121:0], 6'b100011};
      endcase
      if (c == 0) e = e << 9;
    end
    stall_on   = 1'b1;
    stall_addr = 6'd17;
    play_line("stall", 2'd1, 3'd0, 7'h41, e, 105, 1'b1);
    stall_on = 1'b0;
    check_eq("stall_fetches", 128'(addr_log.size()), 128'(16));
    if (addr_log.size() == 16) begin
      check_eq("stall_addr1", 128'(addr_log[1]), 128'(6'd17));
      check_eq("stall_addr15", 128'(addr_log[15]), 128'(6'd31));
    end

    // Abort a line while column 1's request is pending, restart on row 2.
    fill_row(2, 8'h41);
    stall_on   = 1'b1;
    stall_addr = 6'd1;
    text_row   = 2'd0;
    glyph_row  = 3'd0;
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    check_eq("abort_ur_clr", 128'(underrun), 128'(1'b0));
    for (int i = 0; i < 4; i++) tick();
    pix_en = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check_eq("abort_pending_req", 128'(txt_req), 128'(1'b1));
    check_eq("abort_pending_addr", 128'(txt_addr), 128'(6'd1));
    check_eq("abort_mid_pixel", 128'(pixel), 128'(1'b1));
    play_line("restart", 2'd2, 3'd1, 7'h41, 128'({16{6'b100010}}), 96, 1'b0);
    stall_on = 1'b0;
    check_eq("restart_fetches", 128'(addr_log.size()), 128'(16));
    if (addr_log.size() == 16) begin
      check_eq("restart_addr0", 128'(addr_log[0]), 128'(6'd32));
      check_eq("restart_addr1", 128'(addr_log[1]), 128'(6'd33));
      check_eq("restart_addr15", 128'(addr_log[15]), 128'(6'd47));
    end

    // Reset beats a coincident line_start.
    rst        = 1'b1;
    line_start = 1'b1;
    tick();
    rst        = 1'b0;
    line_start = 1'b0;
    check_eq("rst_wins_req", 128'(txt_req), 128'(1'b0));
    tick();
    check_eq("rst_wins_req2", 128'(txt_req), 128'(1'b0));
    check_eq("rst_wins_act", 128'(active), 128'(1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/glyph_fetch_sequencer.md
# glyph_fetch_sequencer

Scanline glyph sequencer for the VGA text console. On each `line_start` it walks the text columns of one character row, fetching each character byte from the shared text buffer through a request/grant port, and looking the glyph up in the character ROM. It extracts the current glyph row and streams it out one pixel per `pix_en`. It sits between the VGA timing generator, the text-buffer arbiter and the external `char_rom` instance.

## Interface
- `COLS`, 16: character cells per text row.
- `ROWS`, 4: text rows.
- `CELL_W`, 6: pixels per cell (5 glyph + 1 gap column).
- `ADDR_W`, $clog2(COLS*ROWS): text-buffer address width.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `line_start` in 1: single-cycle pulse that starts a scanline.
- `glyph_row` in 3: 0..6 = glyph row; 7 = inter-row gap. Latched at `line_start`.
- `text_row` in $clog2(ROWS): text row index. Latched at `line_start`.
- `pix_en` in 1: advance one pixel.
- `txt_req` out 1: text-buffer read request.
- `txt_addr` out ADDR_W: equals `text_row*COLS + col`.
- `txt_gnt` in 1: grant, sampled while `txt_req`=1.
- `txt_data` in 8: character byte, valid the cycle after the grant. Bit 7 = inverse video.
- `rom_addr` out 7: to `char_rom`.
- `rom_data` in 35: combinational glyph from `char_rom`.
- `pixel` out 1: current pixel.
- `active` out 1: `pixel` is meaningful.
- `underrun` out 1: sticky starvation flag.
- `line_done` out 1: one-cycle pulse after the last pixel of the line.

## Operation
- Reset: FSM=IDLE; `txt_req`, `pixel`, `active`, `underrun`, `line_done` = 0; `rom_addr`=0; both buffers empty; column counter = 0.
- FSM states and transitions:
  - IDLE → FETCH on `line_start`.
  - FETCH: `txt_req`=1. → CAPTURE when `txt_gnt`=1.
  - CAPTURE: register `txt_data` into `code`. → LOOKUP.
  - LOOKUP: `rom_addr`=`code[6:0]`; write the slice into the next buffer and set `next_valid`. → WAIT, or → IDLE if col==COLS-1.
  - WAIT: when `next_valid`=0, increment col and → FETCH.
- Glyph slice: pixel (row r, column c) = `rom_data[34-(5r+c)]`, c=0 leftmost.
  - Cell bits = 5 glyph bits followed by one gap bit of 0.
  - `glyph_row`=7 gives all-zero glyph bits.
  - `code[7]`=1 inverts all CELL_W bits, including the gap bit.
- Codes below 32 are passed unchanged to `rom_addr`. The ROM returns a solid block for them.
- Current buffer: CELL_W-bit shift register plus a remaining-pixel count `cur_cnt`.
  - `pixel` = MSB whenever `cur_cnt`>0.
  - On `pix_en` with `cur_cnt`>0: shift left and decrement.
- Transfer next → current when `next_valid` && (`cur_cnt`==0 || (`cur_cnt`==1 && `pix_en`)). The transfer clears `next_valid` and gives gapless cells.
- `active` = 1 from the first transfer of a line until the last cell drains.
- `underrun`: set when `pix_en`=1 while `active`=1, `cur_cnt`==0 and the line is not finished. During starvation `pixel`=0. Cleared only by `line_start` or `rst`.
- `line_done`: pulses the cycle after the last pixel of cell COLS-1 shifts out. `active` drops in that same cycle.
- `line_start` during a line aborts the line:
  - flush both buffers;
  - drop any pending `txt_req`, and ignore `txt_data` for an in-flight grant;
  - clear `underrun`; restart at col 0 with the newly latched row values.
- `line_start` and `rst` in the same cycle: `rst` wins.

## Timing
- `line_start` sampled at cycle T:
  - T+1: `txt_req` for col 0; with `txt_gnt` tied high, the grant is taken in T+1.
  - T+2: CAPTURE.
  - T+3: LOOKUP.
  - T+4: `next_valid`=1.
  - T+5: `active`=1 and `pixel` = cell 0, column 0.
- The timing generator must give at least 5 cycles of lead from `line_start` to the first `pix_en`.
- Steady-state fetch loop is 5 cycles per cell when grants are immediate. This sustains `pix_en` every cycle because CELL_W=6 exceeds 5.
- Each grant wait cycle adds one cycle of latency.
- `pixel`, `active`, `underrun`, `line_done` and `txt_req` are all registered.

## Structure
- Shared package `vgaconsole_pkg` holds:
  - `GLYPH_W`=5, `GLYPH_H`=7, `GLYPH_BITS`=35;
  - `CELL_W` default;
  - the FSM state enum (IDLE, FETCH, CAPTURE, LOOKUP, WAIT).
- One sub-module, `cell_shifter`: current buffer, `cur_cnt` and the transfer rule.
- The FSM, next buffer and glyph-slice logic stay in the top module.
- `char_rom` is instantiated by the parent, not inside this block.

## Test plan
- Reset, with `rst` held 2 cycles → all outputs 0 and FSM IDLE. No `txt_req` until `line_start`.
- All cells = 0x7F, `glyph_row`=0, `txt_gnt`=1, `pix_en` every cycle from T+5:
  - `pixel` repeats 1,1,1,1,1,0 for 16 cells;
  - `line_done` pulses at T+5+96;
  - `underrun`=0.
- Byte 0xA0 (space, inverse) → 1,1,1,1,1,1. Byte 0xC1 → `rom_addr`=0x41.
- `glyph_row`=7 with byte 0x7F → 0,0,0,0,0,0 for every cell. `txt_req` is still issued for every column.
- `txt_gnt` held low 10 cycles on col 1, with `pix_en` every cycle:
  - `underrun`=1 and `pixel`=0 while starved;
  - cells resume in order afterwards;
  - next `line_start` clears `underrun`.
- `text_row`=2 and `line_start` re-issued mid-line while `txt_req` is pending:
  - the request drops;
  - the restart sequence is `txt_addr`=32,33,…;
  - no stale pixels appear.
